ir_queue: RTL and testbench
===========================

# ir_queue

Parametrised instruction register with a small in-order prefetch queue in front of it. Fetched instruction words are pushed into a DEPTH-entry FIFO with a valid/ready handshake. The control unit's `il_in` pops the head word into the instruction register, and `flush_in` discards all prefetched words on a taken branch or jump. Decoded immediates (`ia_out`, `iv_out`) are derived from the registered instruction, so the core datapath sees the same interface as a plain instruction register.

## Interface
- `W`, default 16: instruction word width; legal for W >= 16.
- `DEPTH`, default 4: queue entries; power of two, >= 2.
- `CW`, default $clog2(DEPTH+1): width of `count_out` (derived; do not override).

Ports:
- `clk`  in  1  clock, rising-edge sensitive.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ins_in`  in  W  fetched instruction word.
- `ins_valid_in`  in  1  `ins_in` is valid this cycle.
- `ins_ready_out`  out  1  queue can accept a word; equals !full.
- `il_in`  in  1  instruction load: pop head into IR.
- `flush_in`  in  1  discard queue and invalidate IR.
- `ins_out`  out  W  instruction register contents.
- `ir_valid_out`  out  1  `ins_out` holds a loaded, unflushed instruction.
- `ia_out`  out  W  branch offset: {ir[8:6], ir[2:0]}, 6-bit 2's complement, sign-extended to W.
- `iv_out`  out  W  immediate value: ir[2:0], zero-extended to W.
- `count_out`  out  CW  entries currently queued, 0..DEPTH.
- `full_out`  out  1  count == DEPTH.
- `empty_out`  out  1  count == 0.
- `underflow_out`  out  1  sticky: `il_in` asserted while empty.

## Operation
- Storage: DEPTH x W array with read and write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. A separate CW-bit count is kept so full and empty are unambiguous.
- Push: the queue accepts when `ins_valid_in` and `ins_ready_out`. `ins_in` is written at the write pointer and the write pointer increments. A word offered while full is not accepted; the source must hold it.
- Pop: when `il_in` and !empty, the head word is loaded into the IR, the read pointer increments, and `ir_valid_out` is set to 1.
- `il_in` while empty: the IR and `ir_valid_out` are unchanged and `underflow_out` is set to 1.
- Push and pop in the same cycle: both take effect and count is unchanged. When full, ready is 0, so only the pop occurs. When empty, only the push occurs; there is no bypass, and the pop is counted as an underflow.
- Flush: highest priority. On flush, count and both pointers go to 0, the IR goes to 0, and `ir_valid_out` and `underflow_out` go to 0. Any push or pop in the same cycle is ignored.
- IR hold: when there is no pop and no flush, the IR keeps its value.
- Decode: `ia_out` and `iv_out` are combinational from the IR only, never from the queue head. `ia_out` = {{(W-6){ir[8]}}, ir[8:6], ir[2:0]}. `iv_out` = {(W-3)'b0, ir[2:0]}.
- Reset (`rst_n` low, at any time including mid-transfer): pointers, count and IR go to 0. Array contents are don't-care.

## Timing
- Reset values: `ins_out`=0, `ia_out`=0, `iv_out`=0, `ir_valid_out`=0, `count_out`=0, `empty_out`=1, `full_out`=0, `ins_ready_out`=1, `underflow_out`=0.
- All state updates on the rising edge of `clk`. Reset takes effect immediately on the falling edge of `rst_n`.
- Push-to-IR latency is at least 2 edges. A word pushed at edge N is at the head after N. An `il_in` sampled at edge N+1 makes it visible on `ins_out` after N+1.
- `ins_ready_out`, `full_out`, `empty_out` and `count_out` are decoded from registered count only. No combinational path runs from `ins_valid_in` or `il_in` to any output.
- Sustained throughput is one push and one pop per cycle when 0 < count < DEPTH.
- Ordering is strict FIFO. Words pop in push order across pointer wrap-around.

## Test plan
- Reset, then push 16'h1111, 16'h2222, 16'h3333 on consecutive cycles, then `il_in` for 3 cycles. `ins_out` shows 16'h1111, 16'h2222, 16'h3333 in order, `ir_valid_out`=1, count returns to 0 and `empty_out`=1.
- Fill DEPTH=4 words, keep `ins_valid_in` high with 16'hAAAA. Expect `full_out`=1, `ins_ready_out`=0 and 16'hAAAA not accepted. One pop drops count to 3 and the next cycle accepts 16'hAAAA. Then run 10 more push/pop pairs across pointer wrap; order is preserved.
- Load IR with 16'b0000_0001_1100_0101. Expect `ia_out`=16'hFFFD, i.e. {1,1,1,1,0,1} = -3 sign-extended, and `iv_out`=16'h0005. Load 16'h0047. Expect `ia_out`=16'h000F and `iv_out`=16'h0007.
- With 3 queued words, assert `flush_in` together with `ins_valid_in` and `il_in`. Next cycle: count=0, `ins_out`=0, `ir_valid_out`=0, and the pushed word is absent.
- On an empty queue, assert `il_in` with `ins_valid_in` (16'h5A5A). Expect the IR unchanged, `underflow_out`=1 (sticky) and count=1. `il_in` on the next cycle loads 16'h5A5A.
- Drop `rst_n` asynchronously mid-stream with count=2. All outputs take their reset values before the next clock edge.

Source files
------------

// File: rtl/ir_queue.sv
// Instruction register fed by a small in-order prefetch FIFO.
// The IR is loaded by il_in; flush_in clears the queue and invalidates the IR.
module ir_queue #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  ins_in,
    input  logic          ins_valid_in,
    output logic          ins_ready_out,
    input  logic          il_in,
    input  logic          flush_in,
    output logic [W-1:0]  ins_out,
    output logic          ir_valid_out,
    output logic [W-1:0]  ia_out,
    output logic [W-1:0]  iv_out,
    output logic [CW-1:0] count_out,
    output logic          full_out,
    output logic          empty_out,
    output logic          underflow_out
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_ir;
    logic          r_ir_valid;
    logic          r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_il_empty;

    // Status comes only from the registered count, so no input reaches an output combinationally.
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = ins_valid_in && !w_full && !flush_in;
    assign w_pop      = il_in && !w_empty && !flush_in;
    assign w_il_empty = il_in && w_empty && !flush_in;

    // Array is not reset; contents behind the pointers are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ins_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_ir       <= r_mem[r_rd_ptr];
                r_ir_valid <= 1'b1;
            end
            if (w_il_empty) begin
                r_underflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign ins_ready_out = !w_full;
    assign full_out      = w_full;
    assign empty_out     = w_empty;
    assign count_out     = r_count;
    assign ins_out       = r_ir;
    assign ir_valid_out  = r_ir_valid;
    assign underflow_out = r_underflow;
    assign ia_out        = {{(W-6){r_ir[8]}}, r_ir[8:6], r_ir[2:0]};
    assign iv_out        = {{(W-3){1'b0}}, r_ir[2:0]};

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue: a vector table for single-cycle behaviour plus
// hand sequences for backpressure, pointer wrap and asynchronous reset.
module tb_ir_queue;

    logic        clk;
    logic        rst_n;
    logic [15:0] ins_in;
    logic        ins_valid_in;
    logic        ins_ready_out;
    logic        il_in;
    logic        flush_in;
    logic [15:0] ins_out;
    logic        ir_valid_out;
    logic [15:0] ia_out;
    logic [15:0] iv_out;
    logic [2:0]  count_out;
    logic        full_out;
    logic        empty_out;
    logic        underflow_out;

    int checks = 0;
    int errors = 0;

    ir_queue #(.W(16), .DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ins_in       (ins_in),
        .ins_valid_in (ins_valid_in),
        .ins_ready_out(ins_ready_out),
        .il_in        (il_in),
        .flush_in     (flush_in),
        .ins_out      (ins_out),
        .ir_valid_out (ir_valid_out),
        .ia_out       (ia_out),
        .iv_out       (iv_out),
        .count_out    (count_out),
        .full_out     (full_out),
        .empty_out    (empty_out),
        .underflow_out(underflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic        il;
        logic        fl;
        logic [2:0]  cnt;
        logic [15:0] ins;
        logic        irv;
        logic        uf;
    } vec_t;

    vec_t vt [17];

    function automatic logic [15:0] f_ia(input logic [15:0] x);
        return {{10{x[8]}}, x[8:6], x[2:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic il, input logic fl);
        ins_valid_in = v;
        ins_in       = d;
        il_in        = il;
        flush_in     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ins"},   32'(ins_out), 32'h0);
        check({tag, " ia"},    32'(ia_out), 32'h0);
        check({tag, " iv"},    32'(iv_out), 32'h0);
        check({tag, " irv"},   32'(ir_valid_out), 32'h0);
        check({tag, " cnt"},   32'(count_out), 32'h0);
        check({tag, " empty"}, 32'(empty_out), 32'h1);
        check({tag, " full"},  32'(full_out), 32'h0);
        check({tag, " ready"}, 32'(ins_ready_out), 32'h1);
        check({tag, " uf"},    32'(underflow_out), 32'h0);
    endtask

    logic [15:0] exp_q[$];
    logic [15:0] head;

    initial begin
        //                v   d        il  fl  cnt   ins      irv uf
        vt[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h1111, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd1, 16'h2222, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h3333, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 16'h01C5, 1'b0, 1'b0, 3'd1, 16'h3333, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h01C5, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 16'h0047, 1'b0, 1'b0, 3'd1, 16'h01C5, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0047, 1'b1, 1'b0};
        vt[10] = '{1'b1, 16'h00A1, 1'b0, 1'b0, 3'd1, 16'h0047, 1'b1, 1'b0};
        vt[11] = '{1'b1, 16'h00A2, 1'b0, 1'b0, 3'd2, 16'h0047, 1'b1, 1'b0};
        vt[12] = '{1'b1, 16'h00A3, 1'b0, 1'b0, 3'd3, 16'h0047, 1'b1, 1'b0};
        vt[13] = '{1'b1, 16'h00B0, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0};
        vt[14] = '{1'b1, 16'h5A5A, 1'b1, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b1};
        vt[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h5A5A, 1'b1, 1'b1};
        vt[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        ins_valid_in = 1'b0;
        ins_in = '0;
        il_in = 1'b0;
        flush_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].v, vt[i].d, vt[i].il, vt[i].fl);
            check($sformatf("v%0d cnt", i),   32'(count_out), 32'(vt[i].cnt));
            check($sformatf("v%0d ins", i),   32'(ins_out), 32'(vt[i].ins));
            check($sformatf("v%0d irv", i),   32'(ir_valid_out), 32'(vt[i].irv));
            check($sformatf("v%0d uf", i),    32'(underflow_out), 32'(vt[i].uf));
            check($sformatf("v%0d empty", i), 32'(empty_out), 32'(vt[i].cnt == 3'd0));
            check($sformatf("v%0d full", i),  32'(full_out), 32'(vt[i].cnt == 3'd4));
            check($sformatf("v%0d ready", i), 32'(ins_ready_out), 32'(vt[i].cnt != 3'd4));
            check($sformatf("v%0d ia", i),    32'(ia_out), 32'(f_ia(vt[i].ins)));
            check($sformatf("v%0d iv", i),    32'(iv_out), 32'(vt[i].ins[2:0]));
            if (i == 7) begin
                check("decode1 ia", 32'(ia_out), 32'hFFFD);
                check("decode1 iv", 32'(iv_out), 32'h0005);
            end
            if (i == 9) begin
                check("decode2 ia", 32'(ia_out), 32'h000F);
                check("decode2 iv", 32'(iv_out), 32'h0007);
            end
        end

        // Fill, hold a blocked word, then stream across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h00C0 + 16'(i), 1'b0, 1'b0);
            exp_q.push_back(16'h00C0 + 16'(i));
        end
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
        check("full cnt",   32'(count_out), 32'd4);
        check("full flag",  32'(full_out), 32'h1);
        check("full ready", 32'(ins_ready_out), 32'h0);
        drive(1'b1, 16'hAAAA, 1'b1, 1'b0);
        head = exp_q.pop_front();
        check("fullpop ins", 32'(ins_out), 32'(head));
        check("fullpop cnt", 32'(count_out), 32'd3);
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
        exp_q.push_back(16'hAAAA);
        check("accept cnt", 32'(count_out), 32'd4);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        head = exp_q.pop_front();
        check("pop ins", 32'(ins_out), 32'(head));
        check("pop cnt", 32'(count_out), 32'd3);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0D00 + 16'(i), 1'b1, 1'b0);
            exp_q.push_back(16'h0D00 + 16'(i));
            head = exp_q.pop_front();
            check($sformatf("pair%0d ins", i), 32'(ins_out), 32'(head));
            check($sformatf("pair%0d cnt", i), 32'(count_out), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0000, 1'b1, 1'b0);
            head = exp_q.pop_front();
            check($sformatf("drain%0d ins", i), 32'(ins_out), 32'(head));
        end
        check("drain empty", 32'(empty_out), 32'h1);
        check("drain uf",    32'(underflow_out), 32'h0);

        // Asynchronous reset between edges with two words queued.
        drive(1'b1, 16'h0E01, 1'b0, 1'b0);
        drive(1'b1, 16'h0E02, 1'b0, 1'b0);
        ins_valid_in = 1'b0;
        check("pre-rst cnt", 32'(count_out), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("post-rst cnt", 32'(count_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
